instr_decode: RTL and testbench

- MIPS-subset instruction decoder for the 5-stage pipeline (P5).
- Maps a 32-bit instruction word to datapath control signals, register-field selects and hazard timing (Tuse/Tnew); fully combinational.
- One registered element: a sticky illegal-instruction flag.
- Instantiated per stage (D/E/M/W) so each stage re-decodes its own instr; the M stage uses MemWrite to gate data-memory writes.

---
 rtl/instr_decode_if.sv | 34 +++
 rtl/instr_decode.sv | 185 ++++++++++++++++++
 tb/tb_instr_decode.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_if.sv
// Decoder bus: the instruction word and stage-valid in, decoded control out.
// The slave side is the decoder itself; the master side is whoever feeds it
// (pipeline stage register or testbench).
interface instr_decode_if;
  logic [31:0] instr;
  logic        en;
  logic        RegWrite;
  logic        MemWrite;
  logic [1:0]  RegDst;
  logic [1:0]  WDSel;
  logic        ALUSrc;
  logic [2:0]  ALUOp;
  logic [1:0]  ExtOp;
  logic        Branch;
  logic [1:0]  Jump;
  logic [4:0]  WriteReg;
  logic [1:0]  Tuse_rs;
  logic [1:0]  Tuse_rt;
  logic [1:0]  Tnew;
  logic        illegal;
  logic        illegal_sticky;

  modport slave (
    input  instr, en,
    output RegWrite, MemWrite, RegDst, WDSel, ALUSrc, ALUOp, ExtOp, Branch,
           Jump, WriteReg, Tuse_rs, Tuse_rt, Tnew, illegal, illegal_sticky
  );

  modport master (
    output instr, en,
    input  RegWrite, MemWrite, RegDst, WDSel, ALUSrc, ALUOp, ExtOp, Branch,
           Jump, WriteReg, Tuse_rs, Tuse_rt, Tnew, illegal, illegal_sticky
  );
endinterface

// File: rtl/instr_decode.sv
// MIPS-subset instruction decoder for the 5-stage pipeline.
// Purely combinational decode of instr into datapath controls and hazard
// timing, plus one registered sticky illegal-instruction flag.
// Optional macro DECODE_EXT_EN adds addiu, slt, lb and sb; without it those
// encodings decode as illegal.
module instr_decode (
  input  logic            clk,
  input  logic            reset,   // asynchronous, active-low
  instr_decode_if.slave   dif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  logic [5:0] op;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [5:0] funct;

  assign op    = dif.instr[31:26];
  assign rt    = dif.instr[20:16];
  assign rd    = dif.instr[15:11];
  assign funct = dif.instr[5:0];

  logic       reg_write;
  logic       mem_write;
  logic [1:0] reg_dst;
  logic [1:0] wd_sel;
  logic       alu_src;
  logic [2:0] alu_op;
  logic [1:0] ext_op;
  logic       branch;
  logic [1:0] jump;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic [1:0] tnew;
  logic       illegal;
  logic [4:0] write_reg;

  // Main decode: every output starts at its inactive value (Tuse=3 means the
  // operand is never read), then the recognised encoding switches on its set.
  always_comb begin
    reg_write = 1'b0;
    mem_write = 1'b0;
    reg_dst   = 2'd0;
    wd_sel    = 2'd0;
    alu_src   = 1'b0;
    alu_op    = 3'd0;
    ext_op    = 2'd0;
    branch    = 1'b0;
    jump      = 2'd0;
    tuse_rs   = 2'd3;
    tuse_rt   = 2'd3;
    tnew      = 2'd0;
    illegal   = 1'b0;
    unique case (op)
      OP_RTYPE: begin
        if (dif.instr != 32'h0) begin
          case (funct)
          `ifdef DECODE_EXT_EN
            FN_SLT: begin
              reg_write = 1'b1; reg_dst = 2'd1; alu_op = 3'd3;
              tuse_rs = 2'd1; tuse_rt = 2'd1; tnew = 2'd1;
            end
          `endif
            FN_ADDU: begin
              reg_write = 1'b1; reg_dst = 2'd1; alu_op = 3'd0;
              tuse_rs = 2'd1; tuse_rt = 2'd1; tnew = 2'd1;
            end
            FN_SUBU: begin
              reg_write = 1'b1; reg_dst = 2'd1; alu_op = 3'd1;
              tuse_rs = 2'd1; tuse_rt = 2'd1; tnew = 2'd1;
            end
            FN_JR: begin
              jump = 2'd2; tuse_rs = 2'd0;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      OP_ORI: begin
        reg_write = 1'b1; alu_src = 1'b1; alu_op = 3'd2; ext_op = 2'd0;
        tuse_rs = 2'd1; tnew = 2'd1;
      end
      OP_LUI: begin
        reg_write = 1'b1; alu_src = 1'b1; alu_op = 3'd4; ext_op = 2'd2;
        tnew = 2'd1;
      end
    `ifdef DECODE_EXT_EN
      OP_ADDIU: begin
        reg_write = 1'b1; alu_src = 1'b1; alu_op = 3'd0; ext_op = 2'd1;
        tuse_rs = 2'd1; tnew = 2'd1;
      end
      OP_LB, OP_LW: begin
        reg_write = 1'b1; wd_sel = 2'd1; alu_src = 1'b1; ext_op = 2'd1;
        tuse_rs = 2'd1; tnew = 2'd2;
      end
      OP_SB, OP_SW: begin
        mem_write = 1'b1; alu_src = 1'b1; ext_op = 2'd1;
        tuse_rs = 2'd1; tuse_rt = 2'd2;
      end
    `else
      OP_LW: begin
        reg_write = 1'b1; wd_sel = 2'd1; alu_src = 1'b1; ext_op = 2'd1;
        tuse_rs = 2'd1; tnew = 2'd2;
      end
      OP_SW: begin
        mem_write = 1'b1; alu_src = 1'b1; ext_op = 2'd1;
        tuse_rs = 2'd1; tuse_rt = 2'd2;
      end
    `endif
      OP_BEQ: begin
        branch = 1'b1; alu_op = 3'd1; ext_op = 2'd1;
        tuse_rs = 2'd0; tuse_rt = 2'd0;
      end
      OP_J: begin
        jump = 2'd1;
      end
      OP_JAL: begin
        // jal reads no GPR, so both Tuse stay "unused"
        jump = 2'd1; reg_write = 1'b1; reg_dst = 2'd2; wd_sel = 2'd2;
      end
      default: illegal = 1'b1;
    endcase
  end

  // Destination register resolution; 0 whenever nothing is written so the
  // hazard unit never matches a non-writing instruction.
  always_comb begin
    write_reg = 5'd0;
    if (reg_write) begin
      case (reg_dst)
        2'd0:    write_reg = rt;
        2'd1:    write_reg = rd;
        2'd2:    write_reg = 5'd31;
        default: write_reg = 5'd0;
      endcase
    end
  end

  logic illegal_sticky_q;
  logic illegal_sticky_d;

  // Sticky flag accumulates illegal instructions seen while the stage is valid.
  always_comb begin
    illegal_sticky_d = illegal_sticky_q | (dif.en & illegal);
  end

  // Flag register, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) illegal_sticky_q <= 1'b0;
    else        illegal_sticky_q <= illegal_sticky_d;
  end

  assign dif.RegWrite       = reg_write;
  assign dif.MemWrite       = mem_write;
  assign dif.RegDst         = reg_dst;
  assign dif.WDSel          = wd_sel;
  assign dif.ALUSrc         = alu_src;
  assign dif.ALUOp          = alu_op;
  assign dif.ExtOp          = ext_op;
  assign dif.Branch         = branch;
  assign dif.Jump           = jump;
  assign dif.WriteReg       = write_reg;
  assign dif.Tuse_rs        = tuse_rs;
  assign dif.Tuse_rt        = tuse_rt;
  assign dif.Tnew           = tnew;
  assign dif.illegal        = illegal;
  assign dif.illegal_sticky = illegal_sticky_q;

endmodule

// File: tb/tb_instr_decode.sv
// Testbench for instr_decode: directed instruction vectors, a mnemonic-level
// reference model checked every cycle, plus hand-computed literal checks.
module tb_instr_decode;

  logic clk;
  logic reset;

  instr_decode_if bus ();

  instr_decode dut (
    .clk   (clk),
    .reset (reset),
    .dif   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DECODE_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef enum int {
    M_NOP, M_ADDU, M_SUBU, M_JR, M_ORI, M_LUI, M_LW, M_SW, M_BEQ, M_J, M_JAL,
    M_ADDIU, M_SLT, M_LB, M_SB, M_ILL
  } mnem_t;

  typedef struct packed {
    logic       rw;
    logic       mw;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       alusrc;
    logic [2:0] aluop;
    logic [1:0] extop;
    logic       br;
    logic [1:0] jump;
    logic [4:0] wreg;
    logic [1:0] trs;
    logic [1:0] trt;
    logic [1:0] tnew;
    logic       ill;
  } exp_t;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  logic sticky_m = 1'b0;

  // Name the instruction from its fields.
  function automatic mnem_t classify(input logic [31:0] w);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    if (w == 32'h0) return M_NOP;
    if (op == 6'd0) begin
      if (fn == 6'h21) return M_ADDU;
      if (fn == 6'h23) return M_SUBU;
      if (fn == 6'h08) return M_JR;
      if (fn == 6'h2A && EXT) return M_SLT;
      return M_ILL;
    end
    if (op == 6'h0D) return M_ORI;
    if (op == 6'h0F) return M_LUI;
    if (op == 6'h23) return M_LW;
    if (op == 6'h2B) return M_SW;
    if (op == 6'h04) return M_BEQ;
    if (op == 6'h02) return M_J;
    if (op == 6'h03) return M_JAL;
    if (op == 6'h09 && EXT) return M_ADDIU;
    if (op == 6'h20 && EXT) return M_LB;
    if (op == 6'h28 && EXT) return M_SB;
    return M_ILL;
  endfunction

  function automatic exp_t row(input logic rw, input logic mw, input int rdst,
                               input int wds, input logic asrc, input int aop,
                               input int ext, input logic br, input int jmp,
                               input int trs, input int trt, input int tnw,
                               input logic ill);
    exp_t r;
    r.rw = rw; r.mw = mw; r.regdst = 2'(rdst); r.wdsel = 2'(wds);
    r.alusrc = asrc; r.aluop = 3'(aop); r.extop = 2'(ext); r.br = br;
    r.jump = 2'(jmp); r.wreg = 5'd0; r.trs = 2'(trs); r.trt = 2'(trt);
    r.tnew = 2'(tnw); r.ill = ill;
    return r;
  endfunction

  // Reference: one table row per mnemonic, then the destination register.
  function automatic exp_t model(input logic [31:0] w);
    exp_t r;
    //                   rw mw dst wds src aop ext br jmp trs trt tnw ill
    case (classify(w))
      M_ADDU:  r = row(1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
      M_SUBU:  r = row(1, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0);
      M_SLT:   r = row(1, 0, 1, 0, 0, 3, 0, 0, 0, 1, 1, 1, 0);
      M_JR:    r = row(0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3, 0, 0);
      M_ORI:   r = row(1, 0, 0, 0, 1, 2, 0, 0, 0, 1, 3, 1, 0);
      M_ADDIU: r = row(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 3, 1, 0);
      M_LUI:   r = row(1, 0, 0, 0, 1, 4, 2, 0, 0, 3, 3, 1, 0);
      M_LW,
      M_LB:    r = row(1, 0, 0, 1, 1, 0, 1, 0, 0, 1, 3, 2, 0);
      M_SW,
      M_SB:    r = row(0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 2, 0, 0);
      M_BEQ:   r = row(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
      M_J:     r = row(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 0);
      M_JAL:   r = row(1, 0, 2, 2, 0, 0, 0, 0, 1, 3, 3, 0, 0);
      M_NOP:   r = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0);
      default: r = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0, 1);
    endcase
    if (r.rw) begin
      if (r.regdst == 2'd0)      r.wreg = w[20:16];
      else if (r.regdst == 2'd1) r.wreg = w[15:11];
      else                       r.wreg = 5'd31;
    end
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: instr=%h got %0h expected %0h", name, bus.instr, act, exp);
    end
  endtask

  // Sticky reference: remembers any valid illegal instruction since reset.
  always @(posedge clk or negedge reset) begin
    if (!reset) sticky_m <= 1'b0;
    else if (bus.en && model(bus.instr).ill) sticky_m <= 1'b1;
  end

  // Every-cycle comparison of all outputs against the reference.
  always @(negedge clk) begin
    if (chk_on) begin
      exp_t e;
      e = model(bus.instr);
      cmp("RegWrite", 32'(bus.RegWrite), 32'(e.rw));
      cmp("MemWrite", 32'(bus.MemWrite), 32'(e.mw));
      cmp("RegDst",   32'(bus.RegDst),   32'(e.regdst));
      cmp("WDSel",    32'(bus.WDSel),    32'(e.wdsel));
      cmp("ALUSrc",   32'(bus.ALUSrc),   32'(e.alusrc));
      cmp("ALUOp",    32'(bus.ALUOp),    32'(e.aluop));
      cmp("ExtOp",    32'(bus.ExtOp),    32'(e.extop));
      cmp("Branch",   32'(bus.Branch),   32'(e.br));
      cmp("Jump",     32'(bus.Jump),     32'(e.jump));
      cmp("WriteReg", 32'(bus.WriteReg), 32'(e.wreg));
      cmp("Tuse_rs",  32'(bus.Tuse_rs),  32'(e.trs));
      cmp("Tuse_rt",  32'(bus.Tuse_rt),  32'(e.trt));
      cmp("Tnew",     32'(bus.Tnew),     32'(e.tnew));
      cmp("illegal",  32'(bus.illegal),  32'(e.ill));
      cmp("illegal_sticky", 32'(bus.illegal_sticky), 32'(sticky_m));
    end
  end

  // Drive one instruction just after a rising edge; return just after the
  // following falling edge (after the every-cycle compare has run).
  task automatic apply(input logic [31:0] w, input logic e);
    @(posedge clk);
    #1;
    bus.instr = w;
    bus.en    = e;
    $display("apply instr=%h en=%0d", w, e);
    @(negedge clk);
    #1;
  endtask

  logic [31:0] sweep [14];

  initial begin
    sweep = '{32'h00221823, 32'h3428FFFF, 32'h3C081234, 32'h1109FFFE,
              32'h08000010, 32'h0022182A, 32'h81090000, 32'hA1090000,
              32'h00221800, 32'h00221820, 32'h00000008, 32'h2508FFFF,
              32'h8C1F0000, 32'h00000000};
    reset     = 1'b0;
    bus.instr = 32'h0;
    bus.en    = 1'b0;
    @(negedge clk);
    #1;
    cmp("sticky_in_reset", 32'(bus.illegal_sticky), 32'h0);
    cmp("nop_illegal",     32'(bus.illegal),        32'h0);
    chk_on = 1'b1;
    reset  = 1'b1;

    apply(32'hAD090004, 1'b0);  // sw $t1,4($t0)
    cmp("sw_MemWrite", 32'(bus.MemWrite), 32'h1);
    cmp("sw_RegWrite", 32'(bus.RegWrite), 32'h0);
    cmp("sw_ALUSrc",   32'(bus.ALUSrc),   32'h1);
    cmp("sw_ExtOp",    32'(bus.ExtOp),    32'h1);
    cmp("sw_Tuse_rt",  32'(bus.Tuse_rt),  32'h2);
    cmp("sw_WriteReg", 32'(bus.WriteReg), 32'h0);

    apply(32'h8D090008, 1'b0);  // lw $t1,8($t0)
    cmp("lw_RegWrite", 32'(bus.RegWrite), 32'h1);
    cmp("lw_WDSel",    32'(bus.WDSel),    32'h1);
    cmp("lw_WriteReg", 32'(bus.WriteReg), 32'd9);
    cmp("lw_Tnew",     32'(bus.Tnew),     32'h2);

    apply(32'h00221821, 1'b1);  // addu $3,$1,$2
    cmp("addu_RegDst",   32'(bus.RegDst),   32'h1);
    cmp("addu_WriteReg", 32'(bus.WriteReg), 32'd3);
    cmp("addu_ALUOp",    32'(bus.ALUOp),    32'h0);

    apply(32'h0C000010, 1'b1);  // jal
    cmp("jal_Jump",     32'(bus.Jump),     32'h1);
    cmp("jal_RegDst",   32'(bus.RegDst),   32'h2);
    cmp("jal_WriteReg", 32'(bus.WriteReg), 32'd31);
    cmp("jal_WDSel",    32'(bus.WDSel),    32'h2);

    apply(32'h03E00008, 1'b1);  // jr $ra
    cmp("jr_Jump",    32'(bus.Jump),    32'h2);
    cmp("jr_Tuse_rs", 32'(bus.Tuse_rs), 32'h0);

    apply(32'h00000000, 1'b1);  // nop
    cmp("nop_illegal2", 32'(bus.illegal),  32'h0);
    cmp("nop_RegWrite", 32'(bus.RegWrite), 32'h0);
    cmp("nop_MemWrite", 32'(bus.MemWrite), 32'h0);

    // Illegal with the stage invalid must not set the flag.
    apply(32'hFC000000, 1'b0);
    cmp("ill_illegal",  32'(bus.illegal),  32'h1);
    cmp("ill_MemWrite", 32'(bus.MemWrite), 32'h0);
    cmp("ill_RegWrite", 32'(bus.RegWrite), 32'h0);
    apply(32'h00221821, 1'b1);
    cmp("sticky_en0", 32'(bus.illegal_sticky), 32'h0);

    // Same illegal word with the stage valid sets it, and it holds.
    apply(32'hFC000000, 1'b1);
    apply(32'h00221821, 1'b1);
    cmp("sticky_set", 32'(bus.illegal_sticky), 32'h1);
    apply(32'h8D090008, 1'b1);
    cmp("sticky_hold", 32'(bus.illegal_sticky), 32'h1);

    // Asynchronous clear: reset dropped between edges.
    #1;
    reset = 1'b0;
    #1;
    cmp("sticky_async_clr", 32'(bus.illegal_sticky), 32'h0);
    #1;
    reset = 1'b1;

    apply(32'h2508FFFF, 1'b1);  // addiu $t0,$t0,-1
    if (EXT) begin
      cmp("addiu_RegWrite", 32'(bus.RegWrite), 32'h1);
      cmp("addiu_ExtOp",    32'(bus.ExtOp),    32'h1);
      cmp("addiu_illegal",  32'(bus.illegal),  32'h0);
    end else begin
      cmp("addiu_illegal",  32'(bus.illegal),  32'h1);
      cmp("addiu_RegWrite", 32'(bus.RegWrite), 32'h0);
    end

    for (int i = 0; i < 14; i++) apply(sweep[i], i[0]);

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
